// File: rtl/vga_timing_pkg.sv
// VGA timing package: default mode constants and helpers that derive
// line/frame totals and sync window bounds from porch parameters.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    // Bundle order is {hs, vs, blank}; idle = both syncs inactive, not visible.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    function automatic int unsigned total(
        input int unsigned vis,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return vis + front + sync + back;
    endfunction

    function automatic int unsigned sync_lo(
        input int unsigned vis,
        input int unsigned front
    );
        return vis + front;
    endfunction

    function automatic int unsigned sync_hi(
        input int unsigned vis,
        input int unsigned front,
        input int unsigned sync
    );
        return vis + front + sync;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register that delays the {hs, vs, blank} bundle by DEPTH cycles;
// every stage resets to the idle pattern.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_sync,
    output logic [2:0] o_sync
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No register stage, so reset has to mask the decode directly.
            assign o_sync = i_rst_n ? i_sync : SYNC_IDLE;
        end else begin : g_pipe
            logic [2:0] r_pipe [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= SYNC_IDLE;
                    end
                end else begin
                    r_pipe[0] <= i_sync;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_sync = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync and blank decode,
// frame-start pulse and completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_LO  = 10'(sync_lo(H_VISIBLE, H_FRONT));
    localparam logic [9:0] HS_HI  = 10'(sync_hi(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [9:0] VS_LO  = 10'(sync_lo(V_VISIBLE, V_FRONT));
    localparam logic [9:0] VS_HI  = 10'(sync_hi(V_VISIBLE, V_FRONT, V_SYNC));

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_fs;
    logic [7:0] r_fc;

    logic       w_x_wrap;
    logic       w_y_wrap;
    logic       w_frame_wrap;
    logic       w_hs;
    logic       w_vs;
    logic       w_blank;
    logic [2:0] w_sync_q;

    assign w_x_wrap     = (r_x == H_LAST);
    assign w_y_wrap     = (r_y == V_LAST);
    assign w_frame_wrap = w_x_wrap && w_y_wrap;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_fs <= 1'b0;
            r_fc <= '0;
        end else begin
            r_x  <= w_x_wrap ? 10'd0 : r_x + 10'd1;
            r_fs <= w_frame_wrap;
            if (w_x_wrap) begin
                r_y <= w_y_wrap ? 10'd0 : r_y + 10'd1;
            end
            // Count lands together with the pulse, so both show the new frame.
            if (w_frame_wrap) begin
                r_fc <= r_fc + 8'd1;
            end
        end
    end

    assign w_hs    = !((r_x >= HS_LO) && (r_x < HS_HI));
    assign w_vs    = !((r_y >= VS_LO) && (r_y < VS_HI));
    assign w_blank = (r_x < H_VIS) && (r_y < V_VIS);

    vga_sync_delay #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_sync  ({w_hs, w_vs, w_blank}),
        .o_sync  (w_sync_q)
    );

    assign {hs, vs, blank} = w_sync_q;
    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign frame_start = r_fs;
    assign frame_count = r_fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three parameterizations checked every cycle against a
// cycle-count reference model, with randomized mid-frame reset pulses.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   t     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   b_pulses = 0;

    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_hs, a_vs, a_bl, a_fs;
    logic b_hs, b_vs, b_bl, b_fs;
    logic c_hs, c_vs, c_bl, c_fs;
    logic [7:0] a_fc, b_fc, c_fc;

    vga_timing_gen #(
        .SYNC_DELAY (1)
    ) dut_a (
        .vga_clk (clk), .reset_n (rst_n),
        .DrawX (a_x), .DrawY (a_y),
        .hs (a_hs), .vs (a_vs), .blank (a_bl),
        .frame_start (a_fs), .frame_count (a_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .SYNC_DELAY (0)
    ) dut_b (
        .vga_clk (clk), .reset_n (rst_n),
        .DrawX (b_x), .DrawY (b_y),
        .hs (b_hs), .vs (b_vs), .blank (b_bl),
        .frame_start (b_fs), .frame_count (b_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (10), .H_FRONT (1), .H_SYNC (2), .H_BACK (3),
        .V_VISIBLE (5), .V_FRONT (2), .V_SYNC (1), .V_BACK (3),
        .SYNC_DELAY (3)
    ) dut_c (
        .vga_clk (clk), .reset_n (rst_n),
        .DrawX (c_x), .DrawY (c_y),
        .hs (c_hs), .vs (c_vs), .blank (c_bl),
        .frame_start (c_fs), .frame_count (c_fc)
    );

    // Expected outputs after tt clock edges since reset release.
    function automatic obs_t model(
        input int hv, input int hf, input int hsw, input int hb,
        input int vv, input int vf, input int vsw, input int vb,
        input int d, input int tt, input bit in_rst
    );
        obs_t e;
        int ht, vt, fr, u, ux, uy;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        fr = ht * vt;
        e  = '0;
        if (in_rst) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            return e;
        end
        e.x  = 10'(tt % ht);
        e.y  = 10'((tt / ht) % vt);
        e.fs = (tt > 0) && (tt % fr == 0);
        e.fc = 8'((tt / fr) % 256);
        u = tt - d;
        if (u < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.bl = 1'b0;
        end else begin
            ux = u % ht;
            uy = (u / ht) % vt;
            e.hs = !(ux >= hv + hf && ux < hv + hf + hsw);
            e.vs = !(uy >= vv + vf && uy < vv + vf + vsw);
            e.bl = (ux < hv) && (uy < vv);
        end
        return e;
    endfunction

    task automatic chk1(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)",
                   tag, obs, expv, t);
        end
    endtask

    task automatic chk_obs(input string nm, input obs_t o, input obs_t e);
        chk1({nm, ".DrawX"}, 32'(o.x), 32'(e.x));
        chk1({nm, ".DrawY"}, 32'(o.y), 32'(e.y));
        chk1({nm, ".hs"}, 32'(o.hs), 32'(e.hs));
        chk1({nm, ".vs"}, 32'(o.vs), 32'(e.vs));
        chk1({nm, ".blank"}, 32'(o.bl), 32'(e.bl));
        chk1({nm, ".frame_start"}, 32'(o.fs), 32'(e.fs));
        chk1({nm, ".frame_count"}, 32'(o.fc), 32'(e.fc));
    endtask

    task automatic check_all();
        bit r;
        r = !rst_n;
        chk_obs("A", {a_x, a_y, a_hs, a_vs, a_bl, a_fs, a_fc},
                model(640, 16, 96, 48, 480, 10, 2, 33, 1, t, r));
        chk_obs("B", {b_x, b_y, b_hs, b_vs, b_bl, b_fs, b_fc},
                model(8, 2, 3, 3, 6, 1, 2, 1, 0, t, r));
        chk_obs("C", {c_x, c_y, c_hs, c_vs, c_bl, c_fs, c_fc},
                model(10, 1, 2, 3, 5, 2, 1, 3, 3, t, r));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) t++;
        #2;
        check_all();
        if (b_fs === 1'b1) b_pulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset is asserted and released between clock edges.
    task automatic pulse_reset(input int hold);
        #1 rst_n = 1'b0;
        t = 0;
        b_pulses = 0;
        #1 check_all();
        run(hold);
        #1 rst_n = 1'b1;
        #1 check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        run(3);
        #1 rst_n = 1'b1;
        #1 check_all();
        run(1700);
        for (int k = 0; k < 6; k++) begin
            run(int'($urandom_range(20, 600)));
            pulse_reset(int'($urandom_range(0, 3)));
        end
        run(46500);
        chk1("B.pulse_count", 32'(b_pulses), 32'(t / 160));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
